// File: rtl/cp0_defs.sv
// cp0_defs: shared constants for the CP0 block.
//   - CP0 register indices used by mtc0/mfc0 decode
//   - bit positions of the fixed SR/Cause fields
//   - exception codes written into Cause.ExcCode
package cp0_defs;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned CAUSE_TI = 30;
    localparam int unsigned CAUSE_BD = 31;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

endpackage

// File: rtl/cp0_count_timer.sv
// cp0_count_timer: Count/Compare timer of CP0.
//   clk, reset     clock, async active-high reset
//   count_we_i     load Count from wdata_i (wins over a tick increment)
//   compare_we_i   load Compare from wdata_i and clear TI (wins over a set)
//   wdata_i        mtc0 data
//   count_o        Count register
//   compare_o      Compare register
//   tick_match_o   this cycle's increment lands on Compare (TI set condition)
//   ti_o           sticky timer interrupt flag (Cause.TI)
module cp0_count_timer #(
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        tick_match_o,
    output logic        ti_o
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          tick;
    logic [31:0]   count_inc;

    assign tick      = (presc_q == PRESC_LAST);
    assign count_inc = count_q + 32'd1;
    // Only a real increment can raise TI; a Count write on a tick suppresses it.
    assign tick_match_o = tick & ~count_we_i & (count_inc == compare_q);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we_i)
            count_d = wdata_i;
        else if (tick)
            count_d = count_inc;
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end else if (tick_match_o) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_timer.sv
// cp0_timer: MIPS coprocessor 0 at the M stage with exception/interrupt
// arbitration and a Count/Compare timer interrupt.
//   clk, reset   clock, async active-high reset
//   enable       mtc0 write strobe; CP0Add/CP0In give index and data
//   VPC, BDIn    PC of the M-stage instruction and its delay-slot flag
//   ExcCodeIn    nonzero = exception raised by the M-stage instruction
//   HWInt        level-sensitive external interrupt lines
//   EXLClr       eret commit
//   CP0Out       mfc0 read data (pre-edge register values)
//   EPCOut       exception/eret target
//   Req          take exception or interrupt this cycle
//   IntAck       accepted interrupt includes line ACK_LINE
//   TimerIrq     Cause.TI
module cp0_timer
    import cp0_defs::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          IM_LSB     = 10,
    parameter int          TIMER_LINE = NUM_HW_INT - 1,
    parameter int unsigned COUNT_DIV  = 1,
    parameter int          ACK_LINE   = 2,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0007
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4:0]            CP0Add,
    input  logic [31:0]           CP0In,
    input  logic [31:0]           VPC,
    input  logic                  BDIn,
    input  logic [4:0]            ExcCodeIn,
    input  logic [NUM_HW_INT-1:0] HWInt,
    input  logic                  EXLClr,
    output logic [31:0]           CP0Out,
    output logic [31:0]           EPCOut,
    output logic                  Req,
    output logic                  IntAck,
    output logic                  TimerIrq
);

    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic [NUM_HW_INT-1:0] im_q, im_d;
    logic                  bd_q, bd_d;
    logic [4:0]            exc_q, exc_d;
    logic [NUM_HW_INT-1:0] ip_q, ip_d;
    logic [31:0]           epc_q, epc_d;

    logic [NUM_HW_INT-1:0] pend;
    logic                  int_req, exc_req, wr;
    logic [31:0]           count, compare, sr_val, cause_val;
    logic                  ti, tick_match;

    always_comb begin
        pend             = HWInt;
        pend[TIMER_LINE] = HWInt[TIMER_LINE] | ti;
    end

    assign int_req  = ~exl_q & ie_q & |(pend & im_q);
    assign exc_req  = ~exl_q & (ExcCodeIn != 5'd0);
    assign Req      = int_req | exc_req;
    assign IntAck   = int_req & pend[ACK_LINE] & im_q[ACK_LINE];
    assign EPCOut   = Req ? (BDIn ? VPC - 32'd4 : VPC) : epc_q;
    assign TimerIrq = ti;

    // A taken exception/interrupt swallows any same-cycle mtc0.
    assign wr = enable & ~Req;

    cp0_count_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .count_we_i   (wr && (CP0Add == REG_COUNT)),
        .compare_we_i (wr && (CP0Add == REG_COMPARE)),
        .wdata_i      (CP0In),
        .count_o      (count),
        .compare_o    (compare),
        .tick_match_o (tick_match),
        .ti_o         (ti)
    );

    always_comb begin
        sr_val                        = '0;
        sr_val[SR_IE]                 = ie_q;
        sr_val[SR_EXL]                = exl_q;
        sr_val[IM_LSB +: NUM_HW_INT]  = im_q;
        cause_val                        = '0;
        cause_val[CAUSE_BD]              = bd_q;
        cause_val[CAUSE_TI]              = ti;
        cause_val[IM_LSB +: NUM_HW_INT]  = ip_q;
        cause_val[6:2]                   = exc_q;
    end

    always_comb begin
        case (CP0Add)
            REG_COUNT:   CP0Out = count;
            REG_COMPARE: CP0Out = compare;
            REG_SR:      CP0Out = sr_val;
            REG_CAUSE:   CP0Out = cause_val;
            REG_EPC:     CP0Out = epc_q;
            REG_PRID:    CP0Out = PRID_VAL;
            default:     CP0Out = '0;
        endcase
    end

    always_comb begin
        exl_d = exl_q;
        ie_d  = ie_q;
        im_d  = im_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        ip_d  = pend;
        epc_d = epc_q;
        if (Req) begin
            exl_d = 1'b1;
            bd_d  = BDIn;
            exc_d = int_req ? EXC_INT : ExcCodeIn;
            epc_d = EPCOut;
        end else begin
            if (EXLClr)
                exl_d = 1'b0;
            if (enable && (CP0Add == REG_SR)) begin
                ie_d = CP0In[SR_IE];
                im_d = CP0In[IM_LSB +: NUM_HW_INT];
                // eret owns EXL in the cycle it commits
                if (!EXLClr)
                    exl_d = CP0In[SR_EXL];
            end
            if (enable && (CP0Add == REG_EPC))
                epc_d = CP0In;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            im_q  <= '0;
            bd_q  <= 1'b0;
            exc_q <= '0;
            ip_q  <= '0;
            epc_q <= '0;
        end else begin
            exl_q <= exl_d;
            ie_q  <= ie_d;
            im_q  <= im_d;
            bd_q  <= bd_d;
            exc_q <= exc_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_timer.sv
// tb_cp0_timer: directed bench for cp0_timer with COUNT_DIV=2 and otherwise
// default parameters (IM_LSB=10, TIMER_LINE=5, ACK_LINE=2).
module tb_cp0_timer;
    import cp0_defs::*;

    logic        clk, reset, enable, BDIn, EXLClr;
    logic [4:0]  CP0Add, ExcCodeIn;
    logic [31:0] CP0In, VPC;
    logic [5:0]  HWInt;
    logic [31:0] CP0Out, EPCOut;
    logic        Req, IntAck, TimerIrq;

    int total = 0;
    int bad   = 0;

    cp0_timer #(.COUNT_DIV(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .CP0Add(CP0Add),
        .CP0In(CP0In), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut),
        .Req(Req), .IntAck(IntAck), .TimerIrq(TimerIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        CP0Add = a;
        #1;
        chk(tag, CP0Out, exp);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        enable = 1'b1;
        CP0Add = a;
        CP0In  = d;
        edge1();
        enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; BDIn = 1'b0; EXLClr = 1'b0;
        CP0Add = 5'd0; ExcCodeIn = 5'd0; CP0In = '0; VPC = '0; HWInt = '0;
        #3;
        rdchk("rst_sr", REG_SR, 32'h0);
        rdchk("rst_prid", REG_PRID, 32'h0000_0007);
        chk("rst_req", {31'd0, Req}, 32'd0);
        chk("rst_timerirq", {31'd0, TimerIrq}, 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Interrupt on line 0 from a delay slot
        mtc0(REG_SR, 32'h0000_0401);
        HWInt = 6'b000001; VPC = 32'h3000; BDIn = 1'b1;
        #1;
        chk("int_req", {31'd0, Req}, 32'd1);
        chk("int_epcout", EPCOut, 32'h2FFC);
        chk("int_ack_other_line", {31'd0, IntAck}, 32'd0);
        edge1();
        HWInt = '0; BDIn = 1'b0;
        rdchk("int_cause", REG_CAUSE, 32'h8000_0400);
        rdchk("int_sr_exl", REG_SR, 32'h0000_0403);
        chk("int_req_masked", {31'd0, Req}, 32'd0);
        rdchk("int_epc", REG_EPC, 32'h2FFC);

        // Overflow exception, then eret with a same-cycle SR write
        EXLClr = 1'b1; edge1(); EXLClr = 1'b0;
        rdchk("eret_sr", REG_SR, 32'h0000_0401);
        ExcCodeIn = EXC_OV; VPC = 32'h3010;
        #1;
        chk("ov_req", {31'd0, Req}, 32'd1);
        chk("ov_epcout", EPCOut, 32'h3010);
        edge1();
        ExcCodeIn = 5'd0;
        rdchk("ov_epc", REG_EPC, 32'h3010);
        rdchk("ov_cause", REG_CAUSE, 32'h0000_0030);
        EXLClr = 1'b1;
        mtc0(REG_SR, 32'h0000_0403);
        EXLClr = 1'b0;
        rdchk("eret_mtc0_sr", REG_SR, 32'h0000_0401);

        // Interrupt beats exception; same-cycle EPC write discarded
        mtc0(REG_SR, 32'h0000_1001);
        HWInt = 6'b000100; ExcCodeIn = EXC_ADEL; VPC = 32'h4000;
        enable = 1'b1; CP0Add = REG_EPC; CP0In = 32'hDEAD;
        #1;
        chk("both_req", {31'd0, Req}, 32'd1);
        chk("both_intack", {31'd0, IntAck}, 32'd1);
        chk("both_epcout", EPCOut, 32'h4000);
        edge1();
        enable = 1'b0; HWInt = '0; ExcCodeIn = 5'd0;
        rdchk("both_cause", REG_CAUSE, 32'h0000_1000);
        rdchk("both_epc", REG_EPC, 32'h4000);
        EXLClr = 1'b1; edge1(); EXLClr = 1'b0;
        rdchk("both_eret_sr", REG_SR, 32'h0000_1001);

        // Asynchronous reset with Count=0x55 and EXL=1
        mtc0(REG_COUNT, 32'h55);
        rdchk("pre_rst_count", REG_COUNT, 32'h55);
        ExcCodeIn = EXC_SYSCALL;
        edge1();
        ExcCodeIn = 5'd0;
        rdchk("pre_rst_sr", REG_SR, 32'h0000_1003);
        #1 reset = 1'b1;
        rdchk("mid_rst_sr", REG_SR, 32'h0);
        rdchk("mid_rst_count", REG_COUNT, 32'h0);
        rdchk("mid_rst_epc", REG_EPC, 32'h0);
        chk("mid_rst_req", {31'd0, Req}, 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Timer: prescaler restarts at 0, so ticks fall on even edges E2, E4, ...
        mtc0(REG_SR, 32'h0000_8001);        // E1: IM[5] (timer line), IE
        mtc0(REG_COMPARE, 32'd5);           // E2
        edge1();                            // E3
        mtc0(REG_COUNT, 32'd0);             // E4: tick coincides, write wins
        rdchk("tmr_count0", REG_COUNT, 32'd0);
        for (int i = 0; i < 9; i++) edge1(); // E5..E13
        chk("tmr_ti_e13", {31'd0, TimerIrq}, 32'd0);
        chk("tmr_req_e13", {31'd0, Req}, 32'd0);
        rdchk("tmr_count_e13", REG_COUNT, 32'd4);
        edge1();                            // E14: Count 4->5 == Compare
        chk("tmr_ti_e14", {31'd0, TimerIrq}, 32'd1);
        chk("tmr_req_e14", {31'd0, Req}, 32'd1);
        rdchk("tmr_count_e14", REG_COUNT, 32'd5);
        rdchk("tmr_cause_e14", REG_CAUSE, 32'h4000_0000);
        edge1();                            // E15: interrupt taken
        mtc0(REG_COMPARE, 32'h1000);        // E16
        chk("tmr_ti_cleared", {31'd0, TimerIrq}, 32'd0);

        // Wrap and write-on-tick
        mtc0(REG_COMPARE, 32'd0);           // E17
        mtc0(REG_COUNT, 32'hFFFF_FFFF);     // E18: tick edge
        rdchk("wrap_written", REG_COUNT, 32'hFFFF_FFFF);
        chk("wrap_ti_pre", {31'd0, TimerIrq}, 32'd0);
        edge1();                            // E19: no tick
        rdchk("wrap_hold", REG_COUNT, 32'hFFFF_FFFF);
        edge1();                            // E20: wraps to 0 == Compare
        rdchk("wrap_count", REG_COUNT, 32'd0);
        chk("wrap_ti", {31'd0, TimerIrq}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
